// File: rtl/div.sv
// div: iterative RV32M divider (DIV, DIVU, REM, REMU), one restoring step per clock.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   div_start_i  in   request a division (taken only in IDLE with op_i[2]=1 and no abort)
//   op_i         in   RV32M funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   dividend_i   in   rs1 value, sampled with div_start_i
//   divisor_i    in   rs2 value, sampled with div_start_i
//   rd_addr_i    in   destination register, sampled with div_start_i
//   abort_i      in   kill any in-flight operation
//   div_busy_o   out  operation in flight (START, CALC, END)
//   div_ready_o  out  one-cycle result pulse, also the register-file write enable
//   div_result_o out  quotient or remainder, held until the next completion
//   rd_addr_o    out  destination register, held until the next completion
//
// Normal operations take START + 32 CALC + END; divide-by-zero and signed overflow skip CALC.
// Results are registered out of END, so div_ready_o rises the cycle after END.
module div #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            abort_i,
    output logic            div_busy_o,
    output logic            div_ready_o,
    output logic [XLEN-1:0] div_result_o,
    output logic [4:0]      rd_addr_o
);

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StStart, StCalc, StEnd} state_e;

    state_e          r_state, w_state_next;

    logic [1:0]      r_op;        // op_i[1:0]: bit1 selects remainder, bit0 selects unsigned
    logic [XLEN-1:0] r_a, r_b;    // latched operands
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rem, r_quot, r_dvs;
    logic [4:0]      r_cnt;
    logic            r_neg_q, r_neg_r;
    logic            r_ready;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd_out;

    logic            w_accept, w_signed, w_div_zero, w_ovf;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic [XLEN:0]   w_rem_sh, w_sub;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_step, w_quot_fix, w_rem_fix;

    assign w_accept   = (r_state == StIdle) && div_start_i && op_i[2] && !abort_i;
    assign w_signed   = ~r_op[0];
    assign w_div_zero = (r_b == '0);
    assign w_ovf      = w_signed && (r_a == MinNeg) && (r_b == '1);
    assign w_a_mag    = (w_signed && r_a[XLEN-1]) ? ({XLEN{1'b0}} - r_a) : r_a;
    assign w_b_mag    = (w_signed && r_b[XLEN-1]) ? ({XLEN{1'b0}} - r_b) : r_b;

    // Restoring step. The partial remainder is always below the divisor, so after the shift
    // the 33-bit trial difference is non-negative exactly when its top bit is clear.
    assign w_rem_sh   = {r_rem, r_quot[XLEN-1]};
    assign w_sub      = w_rem_sh - {1'b0, r_dvs};
    assign w_ge       = ~w_sub[XLEN];
    assign w_rem_step = w_ge ? w_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];

    assign w_quot_fix = r_neg_q ? ({XLEN{1'b0}} - r_quot) : r_quot;
    assign w_rem_fix  = r_neg_r ? ({XLEN{1'b0}} - r_rem) : r_rem;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_next = StStart;
            StStart: begin
                if (abort_i)                     w_state_next = StIdle;
                else if (w_div_zero || w_ovf)    w_state_next = StEnd;
                else                             w_state_next = StCalc;
            end
            StCalc: begin
                if (abort_i)                     w_state_next = StIdle;
                else if (r_cnt == 5'd0)          w_state_next = StEnd;
            end
            StEnd:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        div_busy_o   = (r_state != StIdle);
        div_ready_o  = r_ready;
        div_result_o = r_result;
        rd_addr_o    = r_rd_out;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rd     <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op <= op_i[1:0];
                        r_a  <= dividend_i;
                        r_b  <= divisor_i;
                        r_rd <= rd_addr_i;
                    end
                end
                StStart: begin
                    // Special cases preload the final answer with sign correction disabled
                    if (w_div_zero) begin
                        r_quot  <= '1;
                        r_rem   <= r_a;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else if (w_ovf) begin
                        r_quot  <= MinNeg;
                        r_rem   <= '0;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else begin
                        r_quot  <= w_a_mag;
                        r_rem   <= '0;
                        r_dvs   <= w_b_mag;
                        r_neg_q <= w_signed && (r_a[XLEN-1] ^ r_b[XLEN-1]);
                        r_neg_r <= w_signed && r_a[XLEN-1];
                        r_cnt   <= 5'd31;
                    end
                end
                StCalc: begin
                    r_rem  <= w_rem_step;
                    r_quot <= {r_quot[XLEN-2:0], w_ge};
                    r_cnt  <= r_cnt - 5'd1;
                end
                StEnd: begin
                    if (!abort_i) begin
                        r_result <= r_op[1] ? w_rem_fix : w_quot_fix;
                        r_rd_out <= r_rd;
                        r_ready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
module tb_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_start_i = 1'b0;
    logic [2:0]  op_i = 3'b000;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        abort_i = 1'b0;
    logic        div_busy_o;
    logic        div_ready_o;
    logic [31:0] div_result_o;
    logic [4:0]  rd_addr_o;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [2:0] OpDiv = 3'b100, OpDivu = 3'b101, OpRem = 3'b110, OpRemu = 3'b111;

    div #(.XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .div_start_i  (div_start_i),
        .op_i         (op_i),
        .dividend_i   (dividend_i),
        .divisor_i    (divisor_i),
        .rd_addr_i    (rd_addr_i),
        .abort_i      (abort_i),
        .div_busy_o   (div_busy_o),
        .div_ready_o  (div_ready_o),
        .div_result_o (div_result_o),
        .rd_addr_o    (rd_addr_o)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics from plain integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            OpDiv: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            OpDivu: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OpRem: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (b == 0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom % 20;
            default: return $urandom;
        endcase
    endfunction

    // Issue one request and wait (bounded) for div_ready_o; lat counts edges after acceptance
    task automatic run_op(input bit no_wait, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, output logic [31:0] res,
                          output logic [4:0] rdo, output int lat, output int busy_cnt,
                          output bit got);
        if (!no_wait) @(negedge clk);
        div_start_i = 1'b1;
        op_i        = op;
        dividend_i  = a;
        divisor_i   = b;
        rd_addr_i   = rd;
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        lat      = 0;
        got      = 1'b0;
        res      = '0;
        rdo      = '0;
        busy_cnt = div_busy_o ? 1 : 0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (div_ready_o) begin
                got = 1'b1;
                res = div_result_o;
                rdo = rd_addr_o;
            end else if (div_busy_o) begin
                busy_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, bc;
        bit          got;
        #12;
        n_vec++;
        if ({div_busy_o, div_ready_o, div_result_o, rd_addr_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%0b ready=%0b res=%h rd=%0d, want all 0",
                     div_busy_o, div_ready_o, div_result_o, rd_addr_o);
        end
        // First request presented as reset releases is taken at the first edge
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b1, OpDivu, 32'd9, 32'd3, 5'd2, res, rdo, lat, bc, got);
        n_vec++;
        if (!got || lat != 34 || res !== 32'd3 || rdo !== 5'd2) begin
            n_err++;
            $display("FAIL reset_first_req: got=%0b lat=%0d res=%h rd=%0d, want 1 34 3 2",
                     got, lat, res, rdo);
        end
    endtask

    task automatic test_divu_basic();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, bc;
        bit          got;
        run_op(1'b0, OpDivu, 32'd100, 32'd7, 5'd5, res, rdo, lat, bc, got);
        n_vec++;
        if (!got || lat != 34) begin
            n_err++;
            $display("FAIL divu_latency: got=%0b lat=%0d, want ready at 34", got, lat);
        end
        n_vec++;
        if (bc != 34) begin
            n_err++;
            $display("FAIL divu_busy_cycles: got %0d, want 34", bc);
        end
        n_vec++;
        if (res !== 32'd14 || rdo !== 5'd5) begin
            n_err++;
            $display("FAIL divu_result: got %h rd=%0d, want 0000000e rd=5", res, rdo);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (div_ready_o !== 1'b0 || div_result_o !== 32'd14 || rd_addr_o !== 5'd5) begin
            n_err++;
            $display("FAIL divu_pulse_hold: ready=%0b res=%h rd=%0d, want 0 0000000e 5",
                     div_ready_o, div_result_o, rd_addr_o);
        end
    endtask

    task automatic test_signed();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, bc;
        bit          got;
        run_op(1'b0, OpRem, 32'hFFFF_FFF9, 32'd2, 5'd10, res, rdo, lat, bc, got);
        n_vec++;
        if (!got || res !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL rem_neg7_2: got %h, want ffffffff", res);
        end
        run_op(1'b0, OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd11, res, rdo, lat, bc, got);
        n_vec++;
        if (!got || res !== 32'hFFFF_FFFD || lat != 34) begin
            n_err++;
            $display("FAIL div_neg7_2: got %h lat=%0d, want fffffffd lat=34", res, lat);
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [3]  = '{OpDiv, OpDivu, OpRemu};
        logic [31:0] as  [3]  = '{32'h8000_0000, 32'd123, 32'd123};
        logic [31:0] bs  [3]  = '{32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] exp [3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd123};
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, bc;
        bit          got;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, ops[i], as[i], bs[i], 5'(20 + i), res, rdo, lat, bc, got);
            n_vec++;
            if (!got || lat != 2 || bc != 2 || res !== exp[i] || rdo !== 5'(20 + i)) begin
                n_err++;
                $display("FAIL special_%0d: got=%0b lat=%0d busy=%0d res=%h rd=%0d, want lat 2 busy 2 res %h rd %0d",
                         i, got, lat, bc, res, rdo, exp[i], 20 + i);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res;
        logic [4:0]  rd, rdo;
        int          lat, bc;
        bit          got;
        for (int i = 0; i < 40; i++) begin
            op = 3'(4 + ($urandom % 4));
            a  = pick();
            b  = pick();
            rd = 5'($urandom);
            run_op(1'b0, op, a, b, rd, res, rdo, lat, bc, got);
            n_vec++;
            if (!got || res !== model(op, a, b) || rdo !== rd || lat != model_lat(op, a, b)) begin
                n_err++;
                $display("FAIL random_%0d op=%b a=%h b=%h: got=%0b res=%h rd=%0d lat=%0d, want res=%h rd=%0d lat=%0d",
                         i, op, a, b, got, res, rdo, lat, model(op, a, b), rd,
                         model_lat(op, a, b));
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] res, prev;
        logic [4:0]  rdo;
        int          lat, bc, seen;
        bit          got;
        prev = div_result_o;
        @(negedge clk);
        div_start_i = 1'b1;
        op_i        = OpDivu;
        dividend_i  = 32'hFFFF_FFFF;
        divisor_i   = 32'd3;
        rd_addr_i   = 5'd7;
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        abort_i = 1'b1;   // during the 10th CALC cycle
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        n_vec++;
        if (div_busy_o !== 1'b0 || div_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state: busy=%0b ready=%0b, want 0 0", div_busy_o, div_ready_o);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_ready_o) seen++;
        end
        n_vec++;
        if (seen != 0 || div_result_o !== prev) begin
            n_err++;
            $display("FAIL abort_no_ready: ready pulses=%0d res=%h, want 0 pulses res=%h",
                     seen, div_result_o, prev);
        end
        run_op(1'b0, OpDivu, 32'd9, 32'd3, 5'd1, res, rdo, lat, bc, got);
        n_vec++;
        if (!got || res !== 32'd3 || rdo !== 5'd1 || lat != 34) begin
            n_err++;
            $display("FAIL abort_then_divu: got=%0b res=%h rd=%0d lat=%0d, want 3 1 34",
                     got, res, rdo, lat);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        bit got;
        logic [31:0] res;
        logic [4:0]  rdo;
        @(negedge clk);
        div_start_i = 1'b1;
        op_i        = OpDivu;
        dividend_i  = 32'd1000;
        divisor_i   = 32'd7;
        rd_addr_i   = 5'd3;
        @(posedge clk);
        #1;
        // Keep requesting with different operands while busy
        dividend_i = 32'd5;
        divisor_i  = 32'd5;
        rd_addr_i  = 5'd20;
        op_i       = OpRem;
        repeat (10) @(posedge clk);
        #1;
        div_start_i = 1'b0;
        lat = 10;
        got = 1'b0;
        res = '0;
        rdo = '0;
        while (!got && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (div_ready_o) begin
                got = 1'b1;
                res = div_result_o;
                rdo = rd_addr_o;
            end
        end
        n_vec++;
        if (!got || res !== 32'd142 || rdo !== 5'd3 || lat != 34) begin
            n_err++;
            $display("FAIL busy_ignore: got=%0b res=%h rd=%0d lat=%0d, want 0000008e 3 34",
                     got, res, rdo, lat);
        end
    endtask

    task automatic test_idle_corners();
        @(negedge clk);
        div_start_i = 1'b1;
        abort_i     = 1'b1;
        op_i        = OpDivu;
        dividend_i  = 32'd50;
        divisor_i   = 32'd5;
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        abort_i     = 1'b0;
        n_vec++;
        if (div_busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL abort_wins_idle: busy=%0b, want 0", div_busy_o);
        end
        @(negedge clk);
        div_start_i = 1'b1;
        op_i        = 3'b001;   // not a divide
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        n_vec++;
        if (div_busy_o !== 1'b0 || div_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL non_div_op: busy=%0b ready=%0b, want 0 0", div_busy_o, div_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, bc;
        bit          got;
        run_op(1'b0, OpDivu, 32'd1000, 32'd3, 5'd9, res, rdo, lat, bc, got);
        @(negedge clk);
        div_start_i = 1'b1;
        op_i        = OpDiv;
        dividend_i  = 32'd77;
        divisor_i   = 32'd4;
        @(posedge clk);
        #1;
        div_start_i = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({div_busy_o, div_ready_o, div_result_o, rd_addr_o} !== '0 || res !== 32'd333) begin
            n_err++;
            $display("FAIL reset_mid_calc: busy=%0b ready=%0b res=%h rd=%0d prev=%h, want all 0 prev=0000014d",
                     div_busy_o, div_ready_o, div_result_o, rd_addr_o, res);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b1, OpRemu, 32'd100, 32'd7, 5'd4, res, rdo, lat, bc, got);
        n_vec++;
        if (!got || res !== 32'd2 || rdo !== 5'd4 || lat != 34) begin
            n_err++;
            $display("FAIL after_reset_remu: got=%0b res=%h rd=%0d lat=%0d, want 2 4 34",
                     got, res, rdo, lat);
        end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_special();
        test_random();
        test_abort();
        test_busy_ignore();
        test_idle_corners();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Parameter: XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 div_start_i  in  1  request a division; sampled only in IDLE.
REQ-005 op_i  in  3  RV32M funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 dividend_i  in  XLEN  rs1 value; sampled with div_start_i.
REQ-007 divisor_i  in  XLEN  rs2 value; sampled with div_start_i.
REQ-008 rd_addr_i  in  5  destination register; sampled with div_start_i.
REQ-009 abort_i  in  1  kill any in-flight operation (jump or flush from the control unit).
REQ-010 div_busy_o  out  1  operation in flight; drives the execute stage's div_busy_i.
REQ-011 div_ready_o  out  1  one-cycle pulse; result and rd_addr_o valid; doubles as the register-file write enable.
REQ-012 div_result_o  out  XLEN  quotient or remainder.
REQ-013 rd_addr_o  out  5  latched destination register.

Function
REQ-014 FSM states SHALL be IDLE, START, CALC and END, with one state transition per clock.
REQ-015 IDLE SHALL accept a request when div_start_i=1, op_i[2]=1 and abort_i=0: latch operands, op and rd, then go to START.
- Requests with op_i[2]=0 are ignored.
REQ-016 START SHALL resolve special cases and then go to END:
- Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
- Signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
REQ-017 START SHALL otherwise load the operand magnitudes, sign-converted for DIV/REM and raw for DIVU/REMU, set a 5-bit counter to 31, and go to CALC.
REQ-018 CALC SHALL perform one restoring step per cycle:
- shift {rem,quot} left by one;
- subtract the divisor if the remainder is greater than or equal to it;
- set the quotient LSB accordingly;
- decrement the counter.
REQ-019 CALC SHALL go to END after the step performed with counter=0, i.e. exactly 32 CALC cycles.
REQ-020 END SHALL apply sign correction:
- quotient negated when the operand signs differ (signed ops only);
- remainder takes the sign of the dividend.
REQ-021 END SHALL present the selected result on div_result_o and rd_addr_o, assert div_ready_o for that cycle only, and return to IDLE.
REQ-022 Latency, with the request accepted at edge k:
- normal operation: div_ready_o high during the cycle after edge k+34;
- special case: div_ready_o high during the cycle after edge k+2.
REQ-023 div_busy_o SHALL be 1 in START, CALC and END, and 0 in IDLE.
- Back-to-back: a new request is accepted in the IDLE cycle immediately following END.
REQ-024 div_start_i SHALL be ignored while not in IDLE; latched operands remain unaffected.
REQ-025 abort_i=1 in START, CALC or END SHALL force IDLE at the next edge.
- div_ready_o is suppressed (0) in that cycle; div_busy_o is 0 from the next cycle.
REQ-026 abort_i and div_start_i high together in IDLE: abort wins and the request is dropped.
REQ-027 div_result_o and rd_addr_o SHALL hold their last END values until the next END.
REQ-028 All arithmetic SHALL be 32-bit with a 33-bit trial subtraction; no overflow beyond the cases in REQ-016 exists.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE, counter 0, div_busy_o=0, div_ready_o=0, div_result_o=0 and rd_addr_o=0, including mid-operation.
REQ-030 After rst_n deasserts, the first request SHALL be accepted at the first clock edge.

Verification
REQ-031 DIVU 100/7, rd=5 -> div_busy_o high for 34 cycles; then div_ready_o pulse with div_result_o=14 and rd_addr_o=5.
REQ-032 REM 0xFFFFFFF9 (-7) / 2 -> div_result_o=0xFFFFFFFF (-1); DIV with the same operands -> 0xFFFFFFFD (-3).
REQ-033 The following SHALL each give div_ready_o two cycles after acceptance:
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
- DIVU 123/0 -> 0xFFFFFFFF;
- REMU 123/0 -> 123.
REQ-034 abort_i pulsed in the 10th CALC cycle -> no div_ready_o, div_busy_o=0 next cycle; a following DIVU 9/3 -> 3.
REQ-035 div_start_i with new operands while busy -> ignored, and the original result is correct; rst_n low mid-CALC -> all outputs 0 immediately.
